// File: rtl/issue_scoreboard.sv
// issue_scoreboard: decode-side issue stage with register scoreboard, per-FU occupancy
// limits and a single registered dispatch slot. Optional perf counters: ISSUE_PERF_CNT_EN.
module issue_scoreboard #(
    parameter int NUM_FU          = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [4:0]        dec_rs1,
    input  logic [4:0]        dec_rs2,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic [4:0]        dec_rd,
    input  logic              dec_wen,
    input  logic [1:0]        dec_sfu,
    input  logic              dec_halt,
    input  logic              dec_ifence,
    input  logic              flush,
    output logic              iss_valid,
    output logic [1:0]        iss_fu,
    output logic [4:0]        iss_rd,
    output logic              iss_wen,
    input  logic [NUM_FU-1:0] fu_ready,
    input  logic [NUM_FU-1:0] fu_done,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    output logic              fence_req,
    input  logic              fence_done,
    output logic              halted,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       issued_cnt
);

    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_FENCE,
        ST_HALTED
    } state_e;

    state_e           state_q;
    logic             drain_halt_q;
    logic             fence_req_q;
    logic             halted_q;

    logic [31:0]      busy_q, busy_d;
    logic [31:0]      busy_eff, wb_mask;
    logic [CNT_W-1:0] cnt_q [NUM_FU];
    logic [CNT_W-1:0] cnt_d [NUM_FU];

    logic             iss_valid_q, iss_valid_d;
    logic [1:0]       iss_fu_q, iss_fu_d;
    logic [4:0]       iss_rd_q, iss_rd_d;
    logic             iss_wen_q, iss_wen_d;

    logic             in_run, hazard, fire, accept, load, kill, drained;

    assign in_run = (state_q == ST_RUN);
    assign fire   = iss_valid_q && fu_ready[iss_fu_q];

    // A writeback landing this cycle already frees its register for the decoder.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
        wb_mask  = wb_valid ? (32'd1 << wb_rd) : 32'd0;
        busy_eff = busy_q & ~wb_mask;
        hazard   = (dec_use_rs1 && (dec_rs1 != 5'd0) && busy_eff[dec_rs1])
                || (dec_use_rs2 && (dec_rs2 != 5'd0) && busy_eff[dec_rs2])
                || (dec_wen     && (dec_rd  != 5'd0) && busy_eff[dec_rd]);
    end

    assign dec_ready = in_run && !flush && (!iss_valid_q || fire) && !hazard
                    && (cnt_q[dec_sfu] < CNT_MAX);
    assign accept    = dec_valid && dec_ready;
    // Halt and fence.i only steer the FSM; they never occupy the slot or the scoreboard.
    assign load      = accept && !dec_halt && !dec_ifence;
    assign kill      = in_run && flush && iss_valid_q && !fire;

    always_comb begin
        drained = !iss_valid_q && (busy_q == 32'd0);
        for (int i = 0; i < NUM_FU; i++) begin
            if (cnt_q[i] != '0) drained = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            case ({fire && (iss_fu_q == 2'(i)), fu_done[i] && (cnt_q[i] != '0)})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Set on accept is applied last so it wins over a same-cycle writeback clear.
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_fu_d    = iss_fu_q;
        iss_rd_d    = iss_rd_q;
        iss_wen_d   = iss_wen_q;
        busy_d      = busy_q;
        if (wb_valid) busy_d[wb_rd] = 1'b0;
        if (kill && iss_wen_q) busy_d[iss_rd_q] = 1'b0;
        if (load) begin
            iss_valid_d = 1'b1;
            iss_fu_d    = dec_sfu;
            iss_rd_d    = dec_rd;
            iss_wen_d   = dec_wen;
            if (dec_wen) busy_d[dec_rd] = 1'b1;
        end else if (fire || (in_run && flush)) begin
            iss_valid_d = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: scoreboard and FU counters are reset, not left to power-up, since hazards read them at once.
            busy_q      <= 32'd0;
            iss_valid_q <= 1'b0;
            iss_fu_q    <= 2'd0;
            iss_rd_q    <= 5'd0;
            iss_wen_q   <= 1'b0;
            for (int i = 0; i < NUM_FU; i++) cnt_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            busy_q      <= busy_d;
            iss_valid_q <= iss_valid_d;
            iss_fu_q    <= iss_fu_d;
            iss_rd_q    <= iss_rd_d;
            iss_wen_q   <= iss_wen_d;
            for (int i = 0; i < NUM_FU; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_RUN;
            drain_halt_q <= 1'b0;
            fence_req_q  <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept && (dec_halt || dec_ifence)) begin
                        state_q      <= ST_DRAIN;
                        drain_halt_q <= dec_halt;
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        if (drain_halt_q) begin
                            state_q  <= ST_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q     <= ST_FENCE;
                            fence_req_q <= 1'b1;
                        end
                    end
                end
                ST_FENCE: begin
                    if (fence_done) begin
                        state_q     <= ST_RUN;
                        fence_req_q <= 1'b0;
                    end
                end
                default: state_q <= ST_HALTED;
            endcase
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] issued_q, issued_d;

    always_comb begin
        stall_d  = stall_q;
        issued_d = issued_q;
        if (in_run && dec_valid && !dec_ready) stall_d = stall_q + 32'd1;
        if (fire) issued_d = issued_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q  <= 32'd0;
            issued_q <= 32'd0;
        end else begin
            stall_q  <= stall_d;
            issued_q <= issued_d;
        end
    end

    assign stall_cycles = stall_q;
    assign issued_cnt   = issued_q;
`else
    assign stall_cycles = 32'd0;
    assign issued_cnt   = 32'd0;
`endif

    assign iss_valid = iss_valid_q;
    assign iss_fu    = iss_fu_q;
    assign iss_rd    = iss_rd_q;
    assign iss_wen   = iss_wen_q;
    assign fence_req = fence_req_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: cycle-level reference model checked every cycle plus
// directed scenarios with literal expectations.
module tb_issue_scoreboard;

    logic        CLK;
    logic        RST;
    logic        dec_valid, dec_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_use_rs1, dec_use_rs2, dec_wen;
    logic [1:0]  dec_sfu;
    logic        dec_halt, dec_ifence, flush;
    logic        iss_valid, iss_wen;
    logic [1:0]  iss_fu;
    logic [4:0]  iss_rd;
    logic [3:0]  fu_ready, fu_done;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        fence_req, fence_done, halted;
    logic [31:0] stall_cycles, issued_cnt;

`ifdef ISSUE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    issue_scoreboard dut (
        .CLK(CLK), .RST(RST),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_rd(dec_rd), .dec_wen(dec_wen), .dec_sfu(dec_sfu),
        .dec_halt(dec_halt), .dec_ifence(dec_ifence), .flush(flush),
        .iss_valid(iss_valid), .iss_fu(iss_fu), .iss_rd(iss_rd), .iss_wen(iss_wen),
        .fu_ready(fu_ready), .fu_done(fu_done),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .fence_req(fence_req), .fence_done(fence_done), .halted(halted),
        .stall_cycles(stall_cycles), .issued_cnt(issued_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_RUN, M_DRAIN, M_FENCE, M_HALT} mode_e;

    bit          m_on = 1'b0;
    bit          m_busy [32];
    int          m_cnt [4];
    bit          m_sv, m_swen;
    logic [1:0]  m_sfu;
    logic [4:0]  m_srd;
    mode_e       m_mode;
    bit          m_halt_pending, m_freq, m_halted;
    bit [31:0]   m_stall, m_issued;

    bit s_rdy, s_acc, s_fire, s_empty, s_ctrl;
    int s_old;

    function automatic bit pending(input logic [4:0] r);
        return (r != 5'd0) && m_busy[r] && !(wb_valid && (wb_rd == r));
    endfunction

    function automatic bit exp_ready();
        if (m_mode != M_RUN || flush) return 1'b0;
        if (m_sv && !fu_ready[m_sfu]) return 1'b0;
        if (dec_use_rs1 && pending(dec_rs1)) return 1'b0;
        if (dec_use_rs2 && pending(dec_rs2)) return 1'b0;
        if (dec_wen && pending(dec_rd)) return 1'b0;
        if (m_cnt[dec_sfu] >= 4) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            foreach (m_busy[r]) m_busy[r] = 1'b0;
            foreach (m_cnt[f]) m_cnt[f] = 0;
            m_sv = 0; m_swen = 0; m_sfu = 0; m_srd = 0;
            m_mode = M_RUN; m_halt_pending = 0; m_freq = 0; m_halted = 0;
            m_stall = 0; m_issued = 0;
            m_on = 1'b1;
        end else if (m_on) begin
            s_rdy  = exp_ready();
            s_acc  = dec_valid && s_rdy;
            s_fire = m_sv && fu_ready[m_sfu];
            s_ctrl = dec_halt || dec_ifence;
            s_empty = !m_sv;
            foreach (m_busy[r]) if (m_busy[r]) s_empty = 1'b0;
            foreach (m_cnt[f]) if (m_cnt[f] != 0) s_empty = 1'b0;

            if (m_mode == M_RUN && dec_valid && !s_rdy) m_stall++;
            if (s_fire) m_issued++;

            for (int f = 0; f < 4; f++) begin
                s_old = m_cnt[f];
                if (s_fire && m_sfu == 2'(f)) m_cnt[f]++;
                if (fu_done[f] && s_old > 0) m_cnt[f]--;
            end

            if (wb_valid) m_busy[wb_rd] = 1'b0;
            if (m_mode == M_RUN && flush && m_sv && !s_fire && m_swen) m_busy[m_srd] = 1'b0;
            if (s_acc && !s_ctrl) begin
                if (dec_wen && dec_rd != 5'd0) m_busy[dec_rd] = 1'b1;
                m_sv = 1; m_sfu = dec_sfu; m_srd = dec_rd; m_swen = dec_wen;
            end else if (s_fire || (m_mode == M_RUN && flush)) begin
                m_sv = 0;
            end

            case (m_mode)
                M_RUN:   if (s_acc && s_ctrl) begin m_mode = M_DRAIN; m_halt_pending = dec_halt; end
                M_DRAIN: if (s_empty) begin
                             if (m_halt_pending) begin m_mode = M_HALT; m_halted = 1; end
                             else begin m_mode = M_FENCE; m_freq = 1; end
                         end
                M_FENCE: if (fence_done) begin m_mode = M_RUN; m_freq = 0; end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m_on) begin
            check("iss_valid", 32'(iss_valid), 32'(m_sv));
            if (m_sv) begin
                check("iss_fu", 32'(iss_fu), 32'(m_sfu));
                check("iss_rd", 32'(iss_rd), 32'(m_srd));
                check("iss_wen", 32'(iss_wen), 32'(m_swen));
            end
            check("dec_ready", 32'(dec_ready), 32'(exp_ready()));
            check("fence_req", 32'(fence_req), 32'(m_freq));
            check("halted", 32'(halted), 32'(m_halted));
            check("stall_cycles", stall_cycles, PERF ? m_stall : 32'd0);
            check("issued_cnt", issued_cnt, PERF ? m_issued : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
        dec_rd = 0; dec_wen = 0; dec_sfu = 0; dec_halt = 0; dec_ifence = 0;
        flush = 0; fu_done = 0; wb_valid = 0; wb_rd = 0; fence_done = 0;
    endtask

    task automatic put(input logic [4:0] rd, input logic wen, input logic [4:0] rs1,
                       input logic u1, input logic [1:0] sfu);
        idle_in();
        dec_valid = 1; dec_rd = rd; dec_wen = wen; dec_rs1 = rs1; dec_use_rs1 = u1; dec_sfu = sfu;
    endtask

    task automatic drain_all();
        idle_in();
        fu_done = 4'hF;
        repeat (6) tick();
        fu_done = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        RST = 1; idle_in(); fu_ready = 4'h0;
        repeat (2) tick();
        RST = 0;
        #1;
        check("rst_iss_valid", 32'(iss_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fence_req", 32'(fence_req), 32'd0);
        check("rst_issued", issued_cnt, 32'd0);
        check("rst_ready", 32'(dec_ready), 32'd1);

        // add rd=5 -> slot next cycle
        put(5'd5, 1, 5'd0, 0, 2'd0);
        tick();
        idle_in(); #1;
        check("lat1_iss_valid", 32'(iss_valid), 32'd1);
        check("lat1_iss_rd", 32'(iss_rd), 32'd5);
        fu_ready = 4'hF;
        put(5'd5, 1, 5'd0, 0, 2'd1); #1;
        check("waw_stall", 32'(dec_ready), 32'd0);
        put(5'd6, 1, 5'd5, 1, 2'd0); #1;
        check("raw_stall", 32'(dec_ready), 32'd0);
        wb_valid = 1; wb_rd = 5'd5; #1;
        check("raw_bypass", 32'(dec_ready), 32'd1);
        tick();
        idle_in(); tick();
        wb_valid = 1; wb_rd = 5'd6; tick();
        drain_all();

        // x0 destination / source never stalls
        for (int i = 0; i < 3; i++) begin
            put(5'd0, 1, 5'd0, 1, 2'd0); #1;
            check("x0_ready", 32'(dec_ready), 32'd1);
            tick();
        end
        drain_all();

        // DIV occupancy limit
        for (int i = 0; i < 4; i++) begin
            put(5'd0, 0, 5'd0, 0, 2'd2);
            tick();
        end
        idle_in(); repeat (2) tick();
        put(5'd0, 0, 5'd0, 0, 2'd2); #1;
        check("div_full_stall", 32'(dec_ready), 32'd0);
        dec_sfu = 2'd0; #1;
        check("div_other_fu_ok", 32'(dec_ready), 32'd1);
        dec_sfu = 2'd2; fu_done = 4'b0100;
        tick();
        fu_done = 4'b0000; #1;
        check("div_after_done", 32'(dec_ready), 32'd1);
        tick();
        idle_in(); tick();
        drain_all();

        // flush kills an undispatched slot and releases its rd
        fu_ready = 4'h0;
        put(5'd7, 1, 5'd0, 0, 2'd1);
        tick();
        idle_in(); flush = 1; #1;
        check("flush_ready", 32'(dec_ready), 32'd0);
        tick();
        flush = 0; #1;
        check("flush_kill", 32'(iss_valid), 32'd0);
        put(5'd1, 1, 5'd7, 1, 2'd0); #1;
        check("flush_busy_clear", 32'(dec_ready), 32'd1);
        idle_in(); fu_ready = 4'hF; tick();

        // fence.i with two ops in flight
        put(5'd8, 1, 5'd0, 0, 2'd0); tick();
        put(5'd9, 1, 5'd0, 0, 2'd3); tick();
        idle_in(); dec_valid = 1; dec_ifence = 1; #1;
        check("ifence_accept", 32'(dec_ready), 32'd1);
        tick();
        idle_in(); #1;
        check("drain_ready", 32'(dec_ready), 32'd0);
        tick();
        fu_done = 4'b1001; wb_valid = 1; wb_rd = 5'd8; tick();
        fu_done = 4'b0000; wb_rd = 5'd9; tick();
        idle_in();
        n = 0;
        while (!fence_req && n < 20) begin tick(); n++; end
        check("fence_req_set", 32'(fence_req), 32'd1);
        repeat (2) tick();
        check("fence_req_hold", 32'(fence_req), 32'd1);
        fence_done = 1; tick();
        fence_done = 0; #1;
        check("fence_req_drop", 32'(fence_req), 32'd0);
        check("fence_back_run", 32'(dec_ready), 32'd1);

        // halt drains and sticks
        put(5'd10, 1, 5'd0, 0, 2'd1); tick();
        idle_in(); dec_valid = 1; dec_halt = 1; #1;
        check("halt_accept", 32'(dec_ready), 32'd1);
        tick();
        idle_in(); flush = 1; tick();
        idle_in(); fu_done = 4'b0010; wb_valid = 1; wb_rd = 5'd10; tick();
        idle_in();
        n = 0;
        while (!halted && n < 20) begin tick(); n++; end
        check("halted_set", 32'(halted), 32'd1);
        for (int i = 0; i < 5; i++) begin
            put(5'd2, 1, 5'd0, 0, 2'd0); #1;
            check("halted_no_ready", 32'(dec_ready), 32'd0);
            tick();
        end
        idle_in(); RST = 1; tick();
        RST = 0; #1;
        check("rst2_halted", 32'(halted), 32'd0);
        check("rst2_ready", 32'(dec_ready), 32'd1);
        check("rst2_stall", stall_cycles, 32'd0);
        check("rst2_issued", issued_cnt, 32'd0);
        put(5'd3, 1, 5'd0, 0, 2'd0); tick();
        idle_in(); repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
